sseg_scan_rx: RTL and testbench
===============================

SSEG_SCAN_RX -- requirements
Module: sseg_scan_rx

Interface
REQ-001 Parameter SETTLE, default 4: consecutive identical samples required before a digit is accepted; legal range 2..255.
REQ-002 Parameter TIMEOUT, default 1000000: cycles without a completed frame before stale asserts.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 anout  input  4  anode enables, active-low; bit i selects digit i, and bit 0 is the rightmost digit.
REQ-006 sseg_out  input  8  segments, active-low; bits 0..6 are segments a..g and bit 7 is dp.
REQ-007 digits  output  16  last complete frame; nibble i holds digit i.
REQ-008 blank  output  4  digit i was all segments off in the last frame.
REQ-009 bad  output  4  digit i had an unrecognised segment pattern in the last frame.
REQ-010 dp  output  4  decimal point state of digit i in the last frame.
REQ-011 frame_valid  output  1  one-cycle pulse when a new frame is published.
REQ-012 frame_changed  output  1  one-cycle pulse, coincident with frame_valid, when any published field differs from the previous frame.
REQ-013 scan_err  output  1  one-cycle pulse on an illegal anode pattern.
REQ-014 stale  output  1  level; no frame published within TIMEOUT cycles.

Function
REQ-015 The block SHALL register both inputs, so the pair (anout, sseg_out) of cycle n is evaluated in cycle n+1.
REQ-016 Sample classes: exactly one anode bit low = legal; 4'hF = idle; two or more bits low = illegal.
REQ-017 A stability counter SHALL increment while the registered sample equals the previous one, saturating at SETTLE; any change reloads it to 1.
REQ-018 A legal sample SHALL be accepted only in the cycle the counter first reaches SETTLE, so each dwell gives at most one acceptance.
REQ-019 On acceptance the segment bits a..g (inverted to active-high, g..a) SHALL decode as 0x3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F.
REQ-020 All segments off SHALL decode as blank=1 with nibble 0; any other pattern SHALL decode as bad=1 with nibble 0.
REQ-021 The decoded nibble, blank, bad and dp SHALL be written to a shadow slot for the selected digit, and that digit's bit SHALL be set in a 4-bit seen mask.
REQ-022 If a slot is accepted again before the frame completes, the newer value SHALL overwrite it, and the mask SHALL be unchanged.
REQ-023 In the cycle the mask would become 4'hF, the block SHALL copy the shadow (including the same-cycle acceptance) to the outputs, pulse frame_valid, and clear the mask.
REQ-024 Latency: frame_valid SHALL assert SETTLE+1 cycles after the first sample of the completing digit is presented.
REQ-025 An idle sample SHALL reset the stability counter and SHALL NOT accept; mask and shadow SHALL be kept.
REQ-026 An illegal sample SHALL pulse scan_err, reset the counter, and clear the mask; shadow and outputs SHALL be kept.
REQ-027 A timeout counter SHALL clear on frame_valid and otherwise increment, saturating at TIMEOUT.
REQ-028 stale SHALL be 1 while the timeout counter equals TIMEOUT, and SHALL fall in the cycle after frame_valid.
REQ-029 Outputs other than the pulses SHALL change only on frame_valid.

Reset
REQ-030 While Reset=0: digits=0, blank=4'hF, bad=0, dp=0, frame_valid=0, frame_changed=0, scan_err=0, stale=0.
REQ-031 While Reset=0 the mask, shadow, stability counter, timeout counter and input registers SHALL all be cleared.
REQ-032 Reset assertion mid-frame SHALL discard the partial frame, and no frame_valid SHALL follow until four new acceptances occur after release.

Verification
REQ-033 Scan digits 0..3 with patterns 7'h4F, 5B, 06, 3F (inverted on the pins), 8 cycles each -> frame_valid once, digits=16'h3210, blank=0, bad=0, frame_changed=1.
REQ-034 Repeat the identical frame -> frame_valid=1, frame_changed=0, digits=16'h3210.
REQ-035 Dwell on each digit for only SETTLE-1 cycles -> no acceptance, no frame_valid, outputs hold.
REQ-036 Drive anout=4'b1100 mid-frame, then complete the remaining digits -> scan_err pulses once, and no frame_valid until all four digits are rescanned.
REQ-037 Digit 2 carries pattern 7'h00 (active-high, blank) and digit 1 carries 7'h49 (active-high), dp on digit 0 -> blank=4'b0100, bad=4'b0010, dp=4'b0001.
REQ-038 TIMEOUT=100 with no scan -> stale=1 at cycle 100; a valid frame then drops stale the cycle after frame_valid; Reset low mid-scan -> outputs equal REQ-030 values immediately.

Source files
------------

// File: rtl/sseg_scan_rx.sv
// Recovers the four digits of a multiplexed active-low 7-segment scan into a published frame.
// Latency: frame_valid SETTLE+1 cycles after the completing digit appears; no backpressure (pure observer).
module sseg_scan_rx #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  anout,
  input  logic [7:0]  sseg_out,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic [3:0]  bad,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic        scan_err,
  output logic        stale
);
  localparam int              TW      = $clog2(TIMEOUT + 1);
  localparam logic [7:0]      SET_MAX = 8'(SETTLE);
  localparam logic [TW-1:0]   TO_MAX  = TW'(TIMEOUT);

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  bad;
    logic [3:0]  dp;
  } frame_t;

  localparam frame_t FRAME_RST = '{digits: 16'h0000, blank: 4'hF, bad: 4'h0, dp: 4'h0};

  logic [3:0]    an_q, an_prev;
  logic [7:0]    seg_q, seg_prev;
  logic          in_vld;
  logic [7:0]    stab_cnt, stab_nxt;
  logic [3:0]    mask, mask_nxt;
  frame_t        shadow, shadow_nxt, out_q;
  logic          fv_q, fc_q, se_q;
  logic [TW-1:0] to_cnt;

  logic [3:0] sel;
  logic       legal, idle, same, accept, publish, err;
  logic [6:0] seg_ah;
  logic [3:0] nib;
  logic       hit, is_blank;

  assign sel   = ~an_q;
  assign legal = (sel != 4'h0) && ((sel & (sel - 4'd1)) == 4'h0);
  assign idle  = (an_q == 4'hF);
  assign same  = ({an_q, seg_q} == {an_prev, seg_prev});

  always_comb begin
    seg_ah   = ~seg_q[6:0];
    nib      = 4'h0;
    hit      = 1'b1;
    is_blank = (seg_ah == 7'h00);
    case (seg_ah)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    stab_nxt   = stab_cnt;
    mask_nxt   = mask;
    shadow_nxt = shadow;
    accept     = 1'b0;
    publish    = 1'b0;
    err        = 1'b0;
    if (in_vld) begin
      if (legal) begin
        if (!same)
          stab_nxt = 8'd1;
        else if (stab_cnt != SET_MAX)
          stab_nxt = stab_cnt + 8'd1;
        // Only the transition into SET_MAX accepts, so a long dwell yields one acceptance.
        accept = same && (stab_cnt == SET_MAX - 8'd1);
      end else begin
        stab_nxt = 8'd0;
        if (!idle) begin
          err      = 1'b1;
          mask_nxt = 4'h0;
        end
      end
    end
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) begin
          shadow_nxt.digits[4*i +: 4] = nib;
          shadow_nxt.blank[i]         = is_blank;
          shadow_nxt.bad[i]           = !hit && !is_blank;
          shadow_nxt.dp[i]            = ~seg_q[7];
        end
      end
      mask_nxt = mask | sel;
      if (mask_nxt == 4'hF) begin
        publish  = 1'b1;
        mask_nxt = 4'h0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q     <= 4'h0;
      seg_q    <= 8'h00;
      in_vld   <= 1'b0;
      an_prev  <= 4'h0;
      seg_prev <= 8'h00;
      stab_cnt <= 8'd0;
      mask     <= 4'h0;
      shadow   <= '0;
      out_q    <= FRAME_RST;
      fv_q     <= 1'b0;
      fc_q     <= 1'b0;
      se_q     <= 1'b0;
      to_cnt   <= '0;
    end else begin
      an_q     <= anout;
      seg_q    <= sseg_out;
      in_vld   <= 1'b1;
      if (in_vld) begin
        an_prev  <= an_q;
        seg_prev <= seg_q;
      end
      stab_cnt <= stab_nxt;
      mask     <= mask_nxt;
      shadow   <= shadow_nxt;
      fv_q     <= publish;
      fc_q     <= publish && (shadow_nxt != out_q);
      se_q     <= err;
      if (publish)
        out_q <= shadow_nxt;
      // Cleared one cycle after the pulse so stale drops the cycle after frame_valid.
      if (fv_q)
        to_cnt <= '0;
      else if (to_cnt != TO_MAX)
        to_cnt <= to_cnt + TW'(1);
    end
  end

  assign digits        = out_q.digits;
  assign blank         = out_q.blank;
  assign bad           = out_q.bad;
  assign dp            = out_q.dp;
  assign frame_valid   = fv_q;
  assign frame_changed = fc_q;
  assign scan_err      = se_q;
  assign stale         = (to_cnt == TO_MAX);

endmodule

// File: tb/tb_sseg_scan_rx.sv
// Bench for sseg_scan_rx: frame vector table, hand-written corner sequences, and a
// randomized dwell stream checked against a run-length reference model.
module tb_sseg_scan_rx;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  anout;
  logic [7:0]  sseg_out;
  logic [15:0] digits;
  logic [3:0]  blank, bad, dp;
  logic        frame_valid, frame_changed, scan_err, stale;

  always #5 clk = ~clk;

  sseg_scan_rx #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .anout(anout), .sseg_out(sseg_out),
    .digits(digits), .blank(blank), .bad(bad), .dp(dp),
    .frame_valid(frame_valid), .frame_changed(frame_changed),
    .scan_err(scan_err), .stale(stale)
  );

  typedef struct {
    logic [27:0] codes;
    logic [3:0]  dpm;
    logic [15:0] e_dig;
    logic [3:0]  e_blank;
    logic [3:0]  e_bad;
    logic [3:0]  e_dp;
    logic        e_chg;
  } vec_t;

  vec_t        vecs[8];
  logic [6:0]  code_tab[16];
  int          errors = 0, checks = 0;
  int          fv_cnt = 0, se_cnt = 0, fv_k = -1;
  logic [28:0] last_obs = '0;
  logic [28:0] obs_q[$], exp_q[$];
  logic [3:0]  r_an[$];
  logic [7:0]  r_seg[$];
  int          r_len[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] a, input logic [7:0] s);
    anout = a;
    sseg_out = s;
    @(posedge clk);
    #1;
    if (frame_valid) begin
      fv_cnt++;
      last_obs = {frame_changed, digits, blank, bad, dp};
      obs_q.push_back(last_obs);
    end
    if (scan_err) se_cnt++;
  endtask

  task automatic dig(input int d, input logic [6:0] c, input logic dpb, input int n);
    logic [3:0] oh;
    oh = 4'b0001 << d;
    for (int k = 0; k < n; k++) begin
      step(~oh, {~dpb, ~c});
      if (frame_valid) fv_k = k;
    end
  endtask

  task automatic scan_frame(input logic [27:0] codes, input logic [3:0] dpm, input int n);
    for (int d = 0; d < 4; d++) dig(d, codes[7*d +: 7], dpm[d], n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    anout = 4'hF;
    sseg_out = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_reset_state();
    check("reset_fields", {digits, blank, bad, dp}, {16'h0000, 4'hF, 4'h0, 4'h0});
    check("reset_pulses", {frame_valid, frame_changed, scan_err, stale}, 4'h0);
  endtask

  int          f0, s0, errs, nz, zi, nibv;
  int          ii, jj, dd, rr, len;
  logic [3:0]  a, oh, seen;
  logic [7:0]  s, rs;
  logic [6:0]  sa;
  logic        dpb, found, stale_chk, fv_seen;
  logic [27:0] f, prev;
  logic [3:0]  m_dig[4];
  logic        m_blank[4], m_bad[4], m_dp[4];

  initial begin
    code_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    vecs[0] = '{codes: {7'h4F, 7'h5B, 7'h06, 7'h3F}, dpm: 4'h0, e_dig: 16'h3210, e_blank: 4'h0, e_bad: 4'h0, e_dp: 4'h0, e_chg: 1'b1};
    vecs[1] = '{codes: {7'h4F, 7'h5B, 7'h06, 7'h3F}, dpm: 4'h0, e_dig: 16'h3210, e_blank: 4'h0, e_bad: 4'h0, e_dp: 4'h0, e_chg: 1'b0};
    vecs[2] = '{codes: {7'h5E, 7'h39, 7'h7C, 7'h77}, dpm: 4'h0, e_dig: 16'hDCBA, e_blank: 4'h0, e_bad: 4'h0, e_dp: 4'h0, e_chg: 1'b1};
    vecs[3] = '{codes: {7'h6F, 7'h7F, 7'h71, 7'h79}, dpm: 4'hA, e_dig: 16'h98FE, e_blank: 4'h0, e_bad: 4'h0, e_dp: 4'hA, e_chg: 1'b1};
    vecs[4] = '{codes: {7'h06, 7'h00, 7'h49, 7'h3F}, dpm: 4'h1, e_dig: 16'h1000, e_blank: 4'h4, e_bad: 4'h2, e_dp: 4'h1, e_chg: 1'b1};
    vecs[5] = '{codes: {7'h07, 7'h7D, 7'h6D, 7'h66}, dpm: 4'h0, e_dig: 16'h7654, e_blank: 4'h0, e_bad: 4'h0, e_dp: 4'h0, e_chg: 1'b1};
    vecs[6] = '{codes: {7'h00, 7'h00, 7'h00, 7'h00}, dpm: 4'h0, e_dig: 16'h0000, e_blank: 4'hF, e_bad: 4'h0, e_dp: 4'h0, e_chg: 1'b1};
    vecs[7] = '{codes: {7'h00, 7'h00, 7'h00, 7'h00}, dpm: 4'hF, e_dig: 16'h0000, e_blank: 4'hF, e_bad: 4'h0, e_dp: 4'hF, e_chg: 1'b1};

    rst_n = 1'b0;
    anout = 4'hF;
    sseg_out = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      f0 = fv_cnt;
      fv_k = -1;
      scan_frame(vecs[v].codes, vecs[v].dpm, 8);
      check("vec_fv_count", fv_cnt - f0, 1);
      check("vec_fields", last_obs[27:0], {vecs[v].e_dig, vecs[v].e_blank, vecs[v].e_bad, vecs[v].e_dp});
      check("vec_changed", last_obs[28], vecs[v].e_chg);
      check("vec_hold", {digits, blank, bad, dp}, {vecs[v].e_dig, vecs[v].e_blank, vecs[v].e_bad, vecs[v].e_dp});
      if (v == 0) check("latency", fv_k, SETTLE);
    end

    // Dwells one cycle short of SETTLE never accept.
    f0 = fv_cnt;
    repeat (3) scan_frame(vecs[0].codes, 4'h0, SETTLE - 1);
    check("short_no_fv", fv_cnt - f0, 0);
    check("short_hold", {digits, blank, bad, dp}, {16'h0000, 4'hF, 4'h0, 4'hF});

    // Illegal anode pattern mid-frame.
    f0 = fv_cnt;
    s0 = se_cnt;
    dig(0, 7'h3F, 1'b0, 8);
    dig(1, 7'h06, 1'b0, 8);
    step(4'b1100, 8'hFF);
    dig(2, 7'h5B, 1'b0, 8);
    dig(3, 7'h4F, 1'b0, 8);
    check("illegal_scan_err", se_cnt - s0, 1);
    check("illegal_no_fv", fv_cnt - f0, 0);
    check("illegal_hold", {digits, blank, bad, dp}, {16'h0000, 4'hF, 4'h0, 4'hF});
    dig(0, 7'h3F, 1'b0, 8);
    dig(1, 7'h06, 1'b0, 8);
    check("rescan_fv", fv_cnt - f0, 1);
    check("rescan_fields", {digits, blank, bad, dp}, {16'h3210, 4'h0, 4'h0, 4'h0});

    // Stale timing after reset, then recovery with a frame.
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      step(4'hF, 8'hFF);
      if (i == 99) check("stale_before", stale, 0);
      if (i == 100) check("stale_at_timeout", stale, 1);
    end
    fv_seen = 1'b0;
    stale_chk = 1'b0;
    for (int d = 0; d < 4; d++) begin
      oh = 4'b0001 << d;
      for (int k = 0; k < 8; k++) begin
        step(~oh, {1'b1, ~vecs[0].codes[7*d +: 7]});
        if (frame_valid) begin
          check("stale_at_fv", stale, 1);
          fv_seen = 1'b1;
        end else if (fv_seen && !stale_chk) begin
          check("stale_after_fv", stale, 0);
          stale_chk = 1'b1;
        end
      end
    end
    check("stale_fv_seen", {fv_seen, stale_chk}, 2'b11);

    // Asynchronous reset mid-scan discards the partial frame.
    dig(0, 7'h3F, 1'b0, 8);
    dig(1, 7'h06, 1'b0, 8);
    dig(2, 7'h5B, 1'b0, 2);
    rst_n = 1'b0;
    #1;
    check_reset_state();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    f0 = fv_cnt;
    dig(2, 7'h5B, 1'b0, 8);
    dig(3, 7'h4F, 1'b0, 8);
    check("post_reset_no_fv", fv_cnt - f0, 0);
    dig(0, 7'h3F, 1'b0, 8);
    dig(1, 7'h06, 1'b0, 8);
    check("post_reset_fv", fv_cnt - f0, 1);
    check("post_reset_frame", last_obs, {1'b1, 16'h3210, 4'h0, 4'h0, 4'h0});

    // Randomized dwell stream.
    do_reset();
    obs_q.delete();
    s0 = se_cnt;
    for (int n = 0; n < 250; n++) begin
      rr = $urandom_range(0, 19);
      if (rr == 0) a = 4'hF;
      else if (rr == 1) begin
        ii = $urandom_range(0, 3);
        jj = (ii + 1 + $urandom_range(0, 2)) % 4;
        a = 4'hF;
        a[ii] = 1'b0;
        a[jj] = 1'b0;
      end else begin
        dd = $urandom_range(0, 3);
        oh = 4'b0001 << dd;
        a = ~oh;
      end
      rr = $urandom_range(0, 19);
      if (rr == 0) sa = 7'h00;
      else if (rr == 1) sa = 7'($urandom);
      else sa = code_tab[$urandom_range(0, 15)];
      dpb = 1'($urandom_range(0, 1));
      s = {~dpb, ~sa};
      len = $urandom_range(1, 7);
      if (r_an.size() > 0 && r_an[r_an.size()-1] == a && r_seg[r_seg.size()-1] == s)
        r_len[r_len.size()-1] += len;
      else begin
        r_an.push_back(a);
        r_seg.push_back(s);
        r_len.push_back(len);
      end
      for (int k = 0; k < len; k++) step(a, s);
    end
    repeat (12) step(4'hF, 8'hFF);

    seen = 4'h0;
    errs = 0;
    prev = {16'h0000, 4'hF, 4'h0, 4'h0};
    for (int i = 0; i < 4; i++) begin
      m_dig[i] = 4'h0; m_blank[i] = 1'b0; m_bad[i] = 1'b0; m_dp[i] = 1'b0;
    end
    for (int r = 0; r < r_an.size(); r++) begin
      a = r_an[r];
      rs = r_seg[r];
      nz = 0;
      zi = 0;
      for (int b = 0; b < 4; b++) if (!a[b]) begin nz++; zi = b; end
      if (nz >= 2) begin
        errs += r_len[r];
        seen = 4'h0;
      end else if (nz == 1 && r_len[r] >= SETTLE) begin
        sa = ~rs[6:0];
        found = 1'b0;
        nibv = 0;
        for (int v = 0; v < 16; v++) if (code_tab[v] == sa) begin found = 1'b1; nibv = v; end
        m_dig[zi]   = 4'(nibv);
        m_blank[zi] = (sa == 7'h00);
        m_bad[zi]   = !found && (sa != 7'h00);
        m_dp[zi]    = !rs[7];
        seen[zi]    = 1'b1;
        if (seen == 4'hF) begin
          for (int i = 0; i < 4; i++) begin
            f[12 + 4*i +: 4] = m_dig[i];
            f[8 + i] = m_blank[i];
            f[4 + i] = m_bad[i];
            f[i]     = m_dp[i];
          end
          exp_q.push_back({(f != prev), f});
          prev = f;
          seen = 4'h0;
        end
      end
    end
    check("rand_frame_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check("rand_frame", obs_q[i], exp_q[i]);
    check("rand_scan_err", se_cnt - s0, errs);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
